alu_ctrl_pipe: RTL

Registered, parametrised ALU control stage. It sits between instruction decode and execute, and translates (ALUOp, funct) into the execute-stage function code through a valid/ready handshake. The funct-to-code mapping is held in a programmable table whose reset contents are the current fixed mapping. Each table entry carries an execute latency, so the stage can stall for multi-cycle operations such as an iterative shifter, and it counts illegal functs.

---
 rtl/alu_ctrl_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: translates (alu_op, funct) into an execute function code
// through a programmable lookup table, with per-entry stall latency and an illegal-op counter.
module alu_ctrl_pipe #(
   parameter int FUNCT_W     = 6,
   parameter int OUT_W       = 6,
   parameter int NUM_ENTRIES = 8,
   parameter int LAT_W       = 3,
   parameter int CNT_W       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [FUNCT_W-1:0]             funct,
   input  logic [1:0]                     alu_op,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_W-1:0]               out_funct,
   output logic                           out_illegal,
   output logic                           busy,
   input  logic                           cfg_we,
   input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx,
   input  logic                           cfg_en,
   input  logic [FUNCT_W-1:0]             cfg_key,
   input  logic [OUT_W-1:0]               cfg_val,
   input  logic [LAT_W-1:0]               cfg_lat,
   output logic [CNT_W-1:0]               illegal_cnt
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [OUT_W-1:0] CODE_ADD = OUT_W'(6'b001001);
   localparam logic [OUT_W-1:0] CODE_SUB = OUT_W'(6'b001010);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [LAT_W-1:0]   r_cnt;
   logic [OUT_W-1:0]   r_funct;
   logic               r_illegal;
   logic [CNT_W-1:0]   r_ill_cnt;

   logic               r_tbl_en  [NUM_ENTRIES];
   logic [FUNCT_W-1:0] r_tbl_key [NUM_ENTRIES];
   logic [OUT_W-1:0]   r_tbl_val [NUM_ENTRIES];
   logic [LAT_W-1:0]   r_tbl_lat [NUM_ENTRIES];

   logic               w_accept;
   logic               w_hit;
   logic [OUT_W-1:0]   w_hit_val;
   logic [LAT_W-1:0]   w_hit_lat;
   logic [OUT_W-1:0]   w_code;
   logic [LAT_W-1:0]   w_lat;
   logic               w_illegal;

   assign in_ready    = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
   assign w_accept    = in_valid && in_ready;
   assign out_valid   = (r_state == S_HOLD);
   assign busy        = (r_state == S_WAIT);
   assign out_funct   = r_funct;
   assign out_illegal = r_illegal;
   assign illegal_cnt = r_ill_cnt;

   // Decode reads the registered table, so a same-cycle cfg write is not yet visible.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_hit     = 1'b0;
      w_hit_val = '0;
      w_hit_lat = '0;
      w_code    = '0;
      w_lat     = '0;
      w_illegal = 1'b0;
      // Scan downward so the lowest matching index is the last (winning) assignment.
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (r_tbl_en[i] && (r_tbl_key[i] == funct)) begin
            w_hit     = 1'b1;
            w_hit_val = r_tbl_val[i];
            w_hit_lat = r_tbl_lat[i];
         end
      end
      case (alu_op)
         2'b00: w_code = CODE_ADD;
         2'b01: w_code = CODE_SUB;
         2'b10: begin
            if (w_hit) begin
               w_code = w_hit_val;
               w_lat  = w_hit_lat;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (w_lat == '0) ? S_HOLD : S_WAIT;
         S_WAIT: if (r_cnt == LAT_W'(1)) w_next = S_HOLD;
         S_HOLD: begin
            if (w_accept)      w_next = (w_lat == '0) ? S_HOLD : S_WAIT;
            else if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_funct   <= '0;
         r_illegal <= 1'b0;
         r_ill_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_funct   <= w_code;
            r_illegal <= w_illegal;
            r_cnt     <= w_lat;
            if (w_illegal && (r_ill_cnt != '1)) r_ill_cnt <= r_ill_cnt + 1'b1;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // NOTE: the table is register-based and reset, because its reset contents are the default mapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_tbl_en[i]  <= (i < 4);
            r_tbl_key[i] <= '0;
            r_tbl_val[i] <= '0;
            r_tbl_lat[i] <= '0;
         end
         r_tbl_key[0] <= FUNCT_W'(6'b001011);  r_tbl_val[0] <= OUT_W'(6'b001001);
         r_tbl_key[1] <= FUNCT_W'(6'b001101);  r_tbl_val[1] <= OUT_W'(6'b001010);
         r_tbl_key[2] <= FUNCT_W'(6'b010010);  r_tbl_val[2] <= OUT_W'(6'b010001);
         r_tbl_key[3] <= FUNCT_W'(6'b100110);  r_tbl_val[3] <= OUT_W'(6'b100001);
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               r_tbl_en[i]  <= cfg_en;
               r_tbl_key[i] <= cfg_key;
               r_tbl_val[i] <= cfg_val;
               r_tbl_lat[i] <= cfg_lat;
            end
         end
      end
   end

endmodule
